// File: rtl/pwm_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_regs_if
// Description : Register-bus bundle for the PWM configuration register file.
//               Separate read/write strobes, 6-bit byte address, 8-bit data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   read        strobe qualifying data_read
//   write       strobe; data_write is captured on the rising clock edge
//   addr        byte address [5:0]
//   data_write  write data [7:0]
//   data_read   read data [7:0], combinational in the slave
// ============================================================================
interface pwm_regs_if;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport master (
    output read,
    output write,
    output addr,
    output data_write,
    input  data_read
  );

  modport slave (
    input  read,
    input  write,
    input  addr,
    input  data_write,
    output data_read
  );
endinterface
`default_nettype wire

// File: rtl/pwm_regs.sv
`default_nettype none
// ============================================================================
// Module      : pwm_regs
// Description : Byte-addressed configuration/status register file for the PWM
//               generator. Holds counter and PWM configuration fields, exposes
//               the live counter value read-only and emits a one-cycle counter
//               reset pulse on a write to the COUNTER_RESET address.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          register bus (slave side): read, write, addr, data_write,
//                data_read
//   counter_val  live counter value [15:0]
//   period       counter period [15:0]
//   en           counter enable
//   count_reset  one-cycle counter reset pulse
//   upnotdown    count direction (1 = up)
//   prescale     clock prescaler [7:0]
//   pwm_en       PWM output enable
//   functions    PWM function/mode bits [7:0]
//   compare1     compare value 1 [15:0]
//   compare2     compare value 2 [15:0]
// ============================================================================
module pwm_regs (
  input  wire logic         clk,
  input  wire logic         rst,
  pwm_regs_if.slave         bus,
  input  wire logic [15:0]  counter_val,
  output logic      [15:0]  period,
  output logic              en,
  output logic              count_reset,
  output logic              upnotdown,
  output logic      [7:0]   prescale,
  output logic              pwm_en,
  output logic      [7:0]   functions,
  output logic      [15:0]  compare1,
  output logic      [15:0]  compare2
);

  localparam logic [5:0] ADDR_PERIOD_LO = 6'h00;
  localparam logic [5:0] ADDR_PERIOD_HI = 6'h01;
  localparam logic [5:0] ADDR_EN        = 6'h02;
  localparam logic [5:0] ADDR_CMP1_LO   = 6'h03;
  localparam logic [5:0] ADDR_CMP1_HI   = 6'h04;
  localparam logic [5:0] ADDR_CMP2_LO   = 6'h05;
  localparam logic [5:0] ADDR_CMP2_HI   = 6'h06;
  localparam logic [5:0] ADDR_CNT_RST   = 6'h07;
  localparam logic [5:0] ADDR_CNT_LO    = 6'h08;
  localparam logic [5:0] ADDR_CNT_HI    = 6'h09;
  localparam logic [5:0] ADDR_PRESCALE  = 6'h0A;
  localparam logic [5:0] ADDR_DIR       = 6'h0B;
  localparam logic [5:0] ADDR_PWM_EN    = 6'h0C;
  localparam logic [5:0] ADDR_FUNCTIONS = 6'h0D;

  logic [15:0] period_q,    period_d;
  logic [15:0] compare1_q,  compare1_d;
  logic [15:0] compare2_q,  compare2_d;
  logic        en_q,        en_d;
  logic        upnotdown_q, upnotdown_d;
  logic        pwm_en_q,    pwm_en_d;
  logic [7:0]  prescale_q,  prescale_d;
  logic [7:0]  functions_q, functions_d;
  logic        count_reset_q, count_reset_d;

  // Write decode: each byte lane updates independently, no shadowing.
  always_comb begin
    period_d    = period_q;
    compare1_d  = compare1_q;
    compare2_d  = compare2_q;
    en_d        = en_q;
    upnotdown_d = upnotdown_q;
    pwm_en_d    = pwm_en_q;
    prescale_d  = prescale_q;
    functions_d = functions_q;
    // Pulse lasts exactly as long as consecutive writes to COUNTER_RESET.
    count_reset_d = bus.write && (bus.addr == ADDR_CNT_RST);
    if (bus.write) begin
      case (bus.addr)
        ADDR_PERIOD_LO: period_d[7:0]    = bus.data_write;
        ADDR_PERIOD_HI: period_d[15:8]   = bus.data_write;
        ADDR_EN:        en_d             = bus.data_write[0];
        ADDR_CMP1_LO:   compare1_d[7:0]  = bus.data_write;
        ADDR_CMP1_HI:   compare1_d[15:8] = bus.data_write;
        ADDR_CMP2_LO:   compare2_d[7:0]  = bus.data_write;
        ADDR_CMP2_HI:   compare2_d[15:8] = bus.data_write;
        ADDR_PRESCALE:  prescale_d       = bus.data_write;
        ADDR_DIR:       upnotdown_d      = bus.data_write[0];
        ADDR_PWM_EN:    pwm_en_d         = bus.data_write[0];
        ADDR_FUNCTIONS: functions_d      = bus.data_write;
        default: ;  // read-only, write-only strobe, or unmapped
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q      <= '0;
      compare1_q    <= '0;
      compare2_q    <= '0;
      en_q          <= 1'b0;
      upnotdown_q   <= 1'b0;
      pwm_en_q      <= 1'b0;
      prescale_q    <= '0;
      functions_q   <= '0;
      count_reset_q <= 1'b0;
    end else begin
      period_q      <= period_d;
      compare1_q    <= compare1_d;
      compare2_q    <= compare2_d;
      en_q          <= en_d;
      upnotdown_q   <= upnotdown_d;
      pwm_en_q      <= pwm_en_d;
      prescale_q    <= prescale_d;
      functions_q   <= functions_d;
      count_reset_q <= count_reset_d;
    end
  end

  // Read mux: zero-latency, forced to zero when not strobed.
  always_comb begin
    bus.data_read = 8'h00;
    if (bus.read) begin
      case (bus.addr)
        ADDR_PERIOD_LO: bus.data_read = period_q[7:0];
        ADDR_PERIOD_HI: bus.data_read = period_q[15:8];
        ADDR_EN:        bus.data_read = {7'b0, en_q};
        ADDR_CMP1_LO:   bus.data_read = compare1_q[7:0];
        ADDR_CMP1_HI:   bus.data_read = compare1_q[15:8];
        ADDR_CMP2_LO:   bus.data_read = compare2_q[7:0];
        ADDR_CMP2_HI:   bus.data_read = compare2_q[15:8];
        ADDR_CNT_LO:    bus.data_read = counter_val[7:0];
        ADDR_CNT_HI:    bus.data_read = counter_val[15:8];
        ADDR_PRESCALE:  bus.data_read = prescale_q;
        ADDR_DIR:       bus.data_read = {7'b0, upnotdown_q};
        ADDR_PWM_EN:    bus.data_read = {7'b0, pwm_en_q};
        ADDR_FUNCTIONS: bus.data_read = functions_q;
        default:        bus.data_read = 8'h00;
      endcase
    end
  end

  assign period      = period_q;
  assign compare1    = compare1_q;
  assign compare2    = compare2_q;
  assign en          = en_q;
  assign upnotdown   = upnotdown_q;
  assign pwm_en      = pwm_en_q;
  assign prescale    = prescale_q;
  assign functions   = functions_q;
  assign count_reset = count_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_regs
// Description : Self-checking bench for pwm_regs. Table of write/readback
//               vectors plus directed sequences for reset, the counter reset
//               pulse, same-cycle read/write and mid-sequence reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_regs;

  logic        clk;
  logic        rst;
  logic [15:0] counter_val;
  logic [15:0] period, compare1, compare2;
  logic        en, count_reset, upnotdown, pwm_en;
  logic [7:0]  prescale, functions;

  int n_cmp;
  int n_bad;

  pwm_regs_if bus ();

  pwm_regs dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .counter_val (counter_val),
    .period      (period),
    .en          (en),
    .count_reset (count_reset),
    .upnotdown   (upnotdown),
    .prescale    (prescale),
    .pwm_en      (pwm_en),
    .functions   (functions),
    .compare1    (compare1),
    .compare2    (compare2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one write cycle; returns at the following negedge.
  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.write      = 1'b1;
    bus.addr       = a;
    bus.data_write = d;
    @(negedge clk);
    bus.write      = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [5:0] a, input logic [7:0] exp);
    bus.read = 1'b1;
    bus.addr = a;
    #1;
    check(name, {8'h00, bus.data_read}, {8'h00, exp});
    bus.read = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    counter_val = 16'h0000;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.addr = 6'h00;
    bus.data_write = 8'h00;

    //           wr    addr   wdata  exp_rd
    vecs[0]  = '{1'b1, 6'h00, 8'h34, 8'h34};
    vecs[1]  = '{1'b1, 6'h01, 8'h12, 8'h12};
    vecs[2]  = '{1'b1, 6'h03, 8'hAA, 8'hAA};
    vecs[3]  = '{1'b1, 6'h04, 8'h55, 8'h55};
    vecs[4]  = '{1'b1, 6'h05, 8'hCC, 8'hCC};
    vecs[5]  = '{1'b1, 6'h06, 8'h77, 8'h77};
    vecs[6]  = '{1'b1, 6'h02, 8'hFE, 8'h00};  // only bit 0 kept
    vecs[7]  = '{1'b1, 6'h02, 8'h01, 8'h01};
    vecs[8]  = '{1'b1, 6'h0B, 8'h02, 8'h00};
    vecs[9]  = '{1'b1, 6'h0B, 8'hFF, 8'h01};
    vecs[10] = '{1'b1, 6'h0A, 8'h3C, 8'h3C};
    vecs[11] = '{1'b1, 6'h0C, 8'h01, 8'h01};
    vecs[12] = '{1'b1, 6'h0D, 8'hAA, 8'hAA};
    vecs[13] = '{1'b0, 6'h08, 8'h00, 8'hCD};
    vecs[14] = '{1'b0, 6'h09, 8'h00, 8'hAB};
    vecs[15] = '{1'b1, 6'h08, 8'h00, 8'hCD};  // read-only
    vecs[16] = '{1'b1, 6'h09, 8'h00, 8'hAB};
    vecs[17] = '{1'b0, 6'h3F, 8'h00, 8'h00};
    vecs[18] = '{1'b1, 6'h20, 8'h5A, 8'h00};
    vecs[19] = '{1'b1, 6'h0E, 8'hFF, 8'h00};
    vecs[20] = '{1'b0, 6'h07, 8'h00, 8'h00};
    vecs[21] = '{1'b0, 6'h00, 8'h00, 8'h34};
    vecs[22] = '{1'b0, 6'h01, 8'h00, 8'h12};
    vecs[23] = '{1'b0, 6'h04, 8'h00, 8'h55};

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_period",      period,      16'h0000);
    check("rst_compare1",    compare1,    16'h0000);
    check("rst_compare2",    compare2,    16'h0000);
    check("rst_en",          {15'b0, en},        16'h0000);
    check("rst_upnotdown",   {15'b0, upnotdown}, 16'h0000);
    check("rst_pwm_en",      {15'b0, pwm_en},    16'h0000);
    check("rst_prescale",    {8'b0, prescale},   16'h0000);
    check("rst_functions",   {8'b0, functions},  16'h0000);
    check("rst_count_reset", {15'b0, count_reset}, 16'h0000);

    // Table vectors
    counter_val = 16'hABCD;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].wdata);
      else
        @(negedge clk);
      read_check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp_rd);
    end

    // Configuration outputs after the table (unmapped writes must not disturb)
    check("out_period",    period,   16'h1234);
    check("out_compare1",  compare1, 16'h55AA);
    check("out_compare2",  compare2, 16'h77CC);
    check("out_en",        {15'b0, en},        16'h0001);
    check("out_upnotdown", {15'b0, upnotdown}, 16'h0001);
    check("out_prescale",  {8'b0, prescale},   16'h003C);
    check("out_pwm_en",    {15'b0, pwm_en},    16'h0001);
    check("out_functions", {8'b0, functions},  16'h00AA);
    check("out_cnt_rst_idle", {15'b0, count_reset}, 16'h0000);

    // data_read is zero while read=0
    bus.read = 1'b0;
    bus.addr = 6'h00;
    #1;
    check("noread_rd", {8'h00, bus.data_read}, 16'h0000);
    counter_val = 16'h1357;
    read_check("cnt_live_lo", 6'h08, 8'h57);

    // Single counter reset pulse
    @(negedge clk);
    bus.write = 1'b1; bus.addr = 6'h07; bus.data_write = 8'hFF;
    #1;
    check("pulse_before_edge", {15'b0, count_reset}, 16'h0000);
    @(posedge clk); #1;
    check("pulse_high", {15'b0, count_reset}, 16'h0001);
    @(negedge clk);
    bus.write = 1'b0;
    @(posedge clk); #1;
    check("pulse_low", {15'b0, count_reset}, 16'h0000);
    @(posedge clk); #1;
    check("pulse_stays_low", {15'b0, count_reset}, 16'h0000);

    // Back-to-back writes to COUNTER_RESET hold the pulse for two cycles
    @(negedge clk);
    bus.write = 1'b1; bus.addr = 6'h07; bus.data_write = 8'h00;
    @(posedge clk); #1;
    check("b2b_high1", {15'b0, count_reset}, 16'h0001);
    @(posedge clk); #1;
    check("b2b_high2", {15'b0, count_reset}, 16'h0001);
    @(negedge clk);
    bus.write = 1'b0;
    @(posedge clk); #1;
    check("b2b_low", {15'b0, count_reset}, 16'h0000);

    // Same-cycle read and write: old value before the edge, new after
    @(negedge clk);
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 6'h0A; bus.data_write = 8'h77;
    #1;
    check("rw_old", {8'h00, bus.data_read}, 16'h003C);
    @(posedge clk); #1;
    check("rw_new", {8'h00, bus.data_read}, 16'h0077);
    check("rw_prescale", {8'b0, prescale}, 16'h0077);
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;

    // Reset between LSB and MSB writes clears both bytes; reset beats write
    do_write(6'h00, 8'h11);
    check("mid_lsb", period, 16'h1211);
    @(negedge clk);
    rst = 1'b1;
    bus.write = 1'b1; bus.addr = 6'h01; bus.data_write = 8'h22;
    @(negedge clk);
    rst = 1'b0;
    bus.write = 1'b0;
    check("mid_rst_period",   period,   16'h0000);
    check("mid_rst_compare1", compare1, 16'h0000);
    check("mid_rst_en",       {15'b0, en}, 16'h0000);
    check("mid_rst_prescale", {8'b0, prescale}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
